// File: rtl/mdu_pkg.sv
// Shared MDU definitions: operation encodings, read selects, default latencies.
package mips_defs;

    typedef enum logic [2:0] {
        MDU_OP_NONE  = 3'd0,
        MDU_OP_MULT  = 3'd1,
        MDU_OP_MULTU = 3'd2,
        MDU_OP_DIV   = 3'd3,
        MDU_OP_DIVU  = 3'd4,
        MDU_OP_MTHI  = 3'd5,
        MDU_OP_MTLO  = 3'd6
    } mdu_op_e;

    typedef enum logic {
        MDU_ST_IDLE = 1'b0,
        MDU_ST_RUN  = 1'b1
    } mdu_state_e;

    localparam logic MDU_RD_LO = 1'b0;
    localparam logic MDU_RD_HI = 1'b1;

    localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
    localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_if.sv
// MDU request/response bundle between the E stage (master) and the MDU (slave).
interface mdu_if;
    import mips_defs::*;

    logic        start;
    mdu_op_e     op;
    logic [31:0] A;
    logic [31:0] B;
    logic        rd_sel;
    logic        busy;
    logic [31:0] md_out;

    modport master (output start, op, A, B, rd_sel, input busy, md_out);
    modport slave  (input start, op, A, B, rd_sel, output busy, md_out);

endinterface

// File: rtl/mdu_calc.sv
// Combinational MDU datapath: {hi,lo} result and divide-by-zero flag.
// Divider present only when MDU_DIV_EN is defined.
module mdu_calc
    import mips_defs::*;
(
    input  mdu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] res,
    output logic        div_zero
);

    logic signed [63:0] sa64;
    logic signed [63:0] sb64;

    assign sa64 = {{32{a[31]}}, a};
    assign sb64 = {{32{b[31]}}, b};

`ifdef MDU_DIV_EN
    logic signed [31:0] sa32;
    logic signed [31:0] sb32;
    logic signed [31:0] sq;
    logic signed [31:0] sr;

    assign sa32 = a;
    assign sb32 = b;
`endif

    always_comb begin
        res      = '0;
        div_zero = 1'b0;
`ifdef MDU_DIV_EN
        sq = '0;
        sr = '0;
`endif
        case (op)
            MDU_OP_MULT:  res = sa64 * sb64;
            MDU_OP_MULTU: res = {32'd0, a} * {32'd0, b};
`ifdef MDU_DIV_EN
            MDU_OP_DIV: begin
                if (b == '0) begin
                    div_zero = 1'b1;
                end else if (a == 32'h8000_0000 && b == '1) begin
                    // Overflow case handled explicitly: quotient wraps, remainder 0
                    res = {32'd0, 32'h8000_0000};
                end else begin
                    sq  = sa32 / sb32;
                    sr  = sa32 % sb32;
                    res = {sr, sq};
                end
            end
            MDU_OP_DIVU: begin
                if (b == '0) begin
                    div_zero = 1'b1;
                end else begin
                    res = {a % b, a / b};
                end
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with committed HI/LO and a busy counter.
// Optional divider enabled by MDU_DIV_EN.
module mdu
    import mips_defs::*;
#(
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);

    mdu_state_e  state, state_nx;
    logic [31:0] cnt, cnt_nx;
    logic [31:0] hi, lo, hi_pend, lo_pend;
    logic        pend_ok;
    logic        load_pend, commit, wr_hi, wr_lo;
    logic        is_mul, is_div;
    logic [63:0] calc_res;
    logic        calc_div_zero;

    mdu_calc u_calc (
        .op       (bus.op),
        .a        (bus.A),
        .b        (bus.B),
        .res      (calc_res),
        .div_zero (calc_div_zero)
    );

    assign is_mul = (bus.op == MDU_OP_MULT) || (bus.op == MDU_OP_MULTU);
`ifdef MDU_DIV_EN
    assign is_div = (bus.op == MDU_OP_DIV) || (bus.op == MDU_OP_DIVU);
`else
    assign is_div = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= MDU_ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        load_pend = 1'b0;
        commit    = 1'b0;
        wr_hi     = 1'b0;
        wr_lo     = 1'b0;
        case (state)
            MDU_ST_IDLE: begin
                if (bus.start) begin
                    if (is_mul || is_div) begin
                        state_nx  = MDU_ST_RUN;
                        cnt_nx    = is_div ? 32'(DIV_CYCLES) : 32'(MULT_CYCLES);
                        load_pend = 1'b1;
                    end else if (bus.op == MDU_OP_MTHI) begin
                        wr_hi = 1'b1;
                    end else if (bus.op == MDU_OP_MTLO) begin
                        wr_lo = 1'b1;
                    end
                end
            end
            MDU_ST_RUN: begin
                cnt_nx = cnt - 32'd1;
                if (cnt == 32'd1) begin
                    state_nx = MDU_ST_IDLE;
                    commit   = 1'b1;
                end
            end
            default: state_nx = MDU_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            hi_pend <= '0;
            lo_pend <= '0;
            pend_ok <= 1'b0;
        end else begin
            cnt <= cnt_nx;
            if (load_pend) begin
                {hi_pend, lo_pend} <= calc_res;
                pend_ok            <= !calc_div_zero;
            end
            if (commit && pend_ok) begin
                hi <= hi_pend;
                lo <= lo_pend;
            end
            if (wr_hi) hi <= bus.A;
            if (wr_lo) lo <= bus.A;
        end
    end

    assign bus.busy   = (state == MDU_ST_RUN);
    assign bus.md_out = (bus.rd_sel == MDU_RD_HI) ? hi : lo;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases plus randomized ops vs. an arithmetic model.
module tb_mdu;
    import mips_defs::*;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic clk;
    logic reset;
    int   tests;
    int   failed;
    logic [31:0] hi_m, lo_m;

    mdu_if bus();

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        bus.rd_sel = MDU_RD_HI;
        #1 check({tag, "_hi"}, bus.md_out, hi_m);
        bus.rd_sel = MDU_RD_LO;
        #1 check({tag, "_lo"}, bus.md_out, lo_m);
    endtask

    // Reference: result, latency and commit decision from plain arithmetic
    task automatic model(input mdu_op_e o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic do_hi, output logic do_lo,
                         output logic [31:0] nhi, output logic [31:0] nlo);
        longint      sp, q, r;
        logic [63:0] up;
        bit          div_en;
`ifdef MDU_DIV_EN
        div_en = 1'b1;
`else
        div_en = 1'b0;
`endif
        lat = 0; do_hi = 1'b0; do_lo = 1'b0; nhi = '0; nlo = '0;
        case (o)
            MDU_OP_MULT: begin
                sp  = longint'(signed'(a)) * longint'(signed'(b));
                lat = MC; do_hi = 1'b1; do_lo = 1'b1;
                nhi = sp[63:32]; nlo = sp[31:0];
            end
            MDU_OP_MULTU: begin
                up  = {32'd0, a} * {32'd0, b};
                lat = MC; do_hi = 1'b1; do_lo = 1'b1;
                nhi = up[63:32]; nlo = up[31:0];
            end
            MDU_OP_DIV: if (div_en) begin
                lat = DC;
                if (b != 0) begin
                    q = longint'(signed'(a)) / longint'(signed'(b));
                    r = longint'(signed'(a)) % longint'(signed'(b));
                    do_hi = 1'b1; do_lo = 1'b1;
                    nhi = r[31:0]; nlo = q[31:0];
                end
            end
            MDU_OP_DIVU: if (div_en) begin
                lat = DC;
                if (b != 0) begin
                    q = longint'({32'd0, a}) / longint'({32'd0, b});
                    r = longint'({32'd0, a}) % longint'({32'd0, b});
                    do_hi = 1'b1; do_lo = 1'b1;
                    nhi = r[31:0]; nlo = q[31:0];
                end
            end
            MDU_OP_MTHI: begin do_hi = 1'b1; nhi = a; end
            MDU_OP_MTLO: begin do_lo = 1'b1; nlo = a; end
            default: ;
        endcase
    endtask

    task automatic do_op(input string tag, input mdu_op_e o, input logic [31:0] a, input logic [31:0] b);
        int          lat, n;
        logic        dh, dl;
        logic [31:0] nhi, nlo;
        model(o, a, b, lat, dh, dl, nhi, nlo);
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.A = a; bus.B = b;
        @(negedge clk);
        bus.start = 1'b0; bus.op = MDU_OP_NONE; bus.A = $urandom; bus.B = $urandom;
        n = 0;
        while (bus.busy && n < 200) begin
            check_regs({tag, "_inflight"});
            n++;
            @(negedge clk);
        end
        check({tag, "_lat"}, 32'(n), 32'(lat));
        if (dh) hi_m = nhi;
        if (dl) lo_m = nlo;
        check_regs(tag);
    endtask

    initial begin
        mdu_op_e     ro;
        logic [31:0] ra, rb;
        tests = 0; failed = 0;
        hi_m = '0; lo_m = '0;
        bus.start = 1'b0; bus.op = MDU_OP_NONE; bus.A = '0; bus.B = '0; bus.rd_sel = MDU_RD_LO;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check_regs("rst");

        do_op("mult",   MDU_OP_MULT,  32'hFFFF_FFFF, 32'd2);
        do_op("multu",  MDU_OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        do_op("div",    MDU_OP_DIV,   32'hFFFF_FFF9, 32'd2);
        do_op("mthi",   MDU_OP_MTHI,  32'h11,        32'd0);
        do_op("mtlo",   MDU_OP_MTLO,  32'h22,        32'd0);
        do_op("divu0",  MDU_OP_DIVU,  32'd7,         32'd0);
        do_op("divovf", MDU_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        do_op("div8_2", MDU_OP_DIV,   32'd8,         32'd2);
        do_op("none",   MDU_OP_NONE,  32'h1234,      32'h5678);

        // Reset asserted while a MULT is in flight
        @(negedge clk);
        bus.start = 1'b1; bus.op = MDU_OP_MULT; bus.A = 32'd3; bus.B = 32'd4;
        @(negedge clk);
        bus.start = 1'b0; bus.op = MDU_OP_NONE;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        hi_m = '0; lo_m = '0;
        #1 check("arst_busy", 32'(bus.busy), 32'd0);
        check_regs("arst");
        @(negedge clk);
        reset = 1'b1;
        do_op("post_rst_mtlo", MDU_OP_MTLO, 32'd5, 32'd0);

        for (int i = 0; i < 40; i++) begin
            ro = mdu_op_e'(3'($urandom_range(0, 6)));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            if ($urandom_range(0, 9) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            do_op("rand", ro, ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
